// File: rtl/sobel_stream_engine_if.sv
// sobel_stream_engine_if: control, status and DPBRAM ports of the Sobel engine
interface sobel_stream_engine_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 12
);
    logic                  i_en;
    logic                  i_run;
    logic                  i_mode;
    logic [DATA_WIDTH-1:0] i_thresh;
    logic                  o_idle;
    logic                  o_read;
    logic                  o_write;
    logic                  o_done;
    logic                  src_ce;
    logic [ADDR_WIDTH-1:0] src_addr;
    logic [DATA_WIDTH-1:0] src_q;
    logic                  dst_ce;
    logic                  dst_we;
    logic [ADDR_WIDTH-1:0] dst_addr;
    logic [DATA_WIDTH-1:0] dst_d;
    modport master (
        input  i_en, i_run, i_mode, i_thresh, src_q,
        output o_idle, o_read, o_write, o_done, src_ce, src_addr, dst_ce, dst_we, dst_addr, dst_d
    );
    modport slave (
        output i_en, i_run, i_mode, i_thresh, src_q,
        input  o_idle, o_read, o_write, o_done, src_ce, src_addr, dst_ce, dst_we, dst_addr, dst_d
    );
endinterface

// File: rtl/sobel_stream_engine.sv
// sobel_stream_engine: streams an image from a source DPBRAM through a 3x3 Sobel filter into a destination DPBRAM
module sobel_stream_engine #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 12,
    parameter int IMG_W      = 64,
    parameter int IMG_H      = 64
) (
    input logic                   clk,
    input logic                   rst,
    sobel_stream_engine_if.master bus
);
    localparam int GW = DATA_WIDTH + 3;
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [ADDR_WIDTH-1:0] LAST_RD = ADDR_WIDTH'(IMG_W * IMG_H - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_WR = ADDR_WIDTH'((IMG_H - 1) * IMG_W - 2);
    localparam logic [ADDR_WIDTH-1:0] CTR_OFS = ADDR_WIDTH'(IMG_W + 1);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    state_t st, nxt;
    logic [ADDR_WIDTH-1:0] rd_cnt, a1, a2, dst_addr_q;
    logic [CW-1:0] col, c1;
    logic [RW-1:0] row, r1;
    logic v1, v2, dst_v, mode_q;
    logic [DATA_WIDTH-1:0] thr_q, dst_d_q, sat, res;
    logic [2:0][2:0][DATA_WIDTH-1:0] win;
    logic [DATA_WIDTH-1:0] lb0 [IMG_W];
    logic [DATA_WIDTH-1:0] lb1 [IMG_W];
    logic [GW-1:0] gx, gy, ax, ay, mag;

    // state register
    always_ff @(posedge clk)
        if (rst) st <= IDLE;
        else     st <= nxt;

    // next state; every transition waits for an enabled cycle
    always_comb begin
        nxt = st;
        if (bus.i_en)
            case (st)
                IDLE:    nxt = bus.i_run ? RUN : IDLE;
                RUN:     nxt = (rd_cnt == LAST_RD) ? DRAIN : RUN;
                DRAIN:   nxt = (dst_v && dst_addr_q == LAST_WR) ? DONE : DRAIN;
                default: nxt = IDLE;
            endcase
    end

    // raster read counters plus mode/threshold captured at start
    always_ff @(posedge clk)
        if (rst) begin
            rd_cnt <= '0;
            col    <= '0;
            row    <= '0;
            mode_q <= 1'b0;
            thr_q  <= '0;
        end else if (bus.i_en) begin
            if (st == IDLE && bus.i_run) begin
                rd_cnt <= '0;
                col    <= '0;
                row    <= '0;
                mode_q <= bus.i_mode;
                thr_q  <= bus.i_thresh;
            end else if (st == RUN) begin
                rd_cnt <= rd_cnt + 1'b1;
                col    <= (col == CW'(IMG_W - 1)) ? '0 : col + 1'b1;
                row    <= (col == CW'(IMG_W - 1)) ? row + 1'b1 : row;
            end
        end

    // pipeline: read issue -> window shift -> registered result
    always_ff @(posedge clk)
        if (rst) begin
            v1         <= 1'b0;
            v2         <= 1'b0;
            dst_v      <= 1'b0;
            a1         <= '0;
            a2         <= '0;
            c1         <= '0;
            r1         <= '0;
            win        <= '0;
            dst_addr_q <= '0;
            dst_d_q    <= '0;
        end else if (bus.i_en) begin
            v1 <= st == RUN;
            a1 <= rd_cnt;
            c1 <= col;
            r1 <= row;
            v2 <= v1 && r1 >= RW'(2) && c1 >= CW'(2);
            a2 <= a1 - CTR_OFS;
            if (v1) begin
                win[0][1:0] <= win[0][2:1];
                win[1][1:0] <= win[1][2:1];
                win[2][1:0] <= win[2][2:1];
                win[0][2]   <= lb0[c1];
                win[1][2]   <= lb1[c1];
                win[2][2]   <= bus.src_q;
            end
            dst_v      <= v2;
            dst_addr_q <= a2;
            dst_d_q    <= res;
        end

    // line buffers: lb1 holds the previous row, lb0 the row before it
    always_ff @(posedge clk)
        if (bus.i_en && v1) begin
            lb0[c1] <= lb1[c1];
            lb1[c1] <= bus.src_q;
        end

    // gradients, L1 magnitude with saturation, and output mode select
    always_comb begin
        gx  = (GW'(win[0][2]) + (GW'(win[1][2]) << 1) + GW'(win[2][2]))
            - (GW'(win[0][0]) + (GW'(win[1][0]) << 1) + GW'(win[2][0]));
        gy  = (GW'(win[2][0]) + (GW'(win[2][1]) << 1) + GW'(win[2][2]))
            - (GW'(win[0][0]) + (GW'(win[0][1]) << 1) + GW'(win[0][2]));
        ax  = gx[GW-1] ? -gx : gx;
        ay  = gy[GW-1] ? -gy : gy;
        mag = ax + ay;
        sat = |mag[GW-1:DATA_WIDTH] ? '1 : mag[DATA_WIDTH-1:0];
        res = mode_q ? ((sat >= thr_q) ? '1 : '0) : sat;
    end

    assign bus.o_idle   = st == IDLE;
    assign bus.o_read   = st == RUN;
    assign bus.o_done   = st == DONE && bus.i_en;
    assign bus.src_ce   = st == RUN && bus.i_en;
    assign bus.src_addr = rd_cnt;
    assign bus.dst_ce   = dst_v && bus.i_en;
    assign bus.dst_we   = dst_v && bus.i_en;
    assign bus.o_write  = dst_v && bus.i_en;
    assign bus.dst_addr = dst_addr_q;
    assign bus.dst_d    = dst_d_q;
endmodule

// File: tb/tb_sobel_stream_engine.sv
// tb_sobel_stream_engine: directed runs of the Sobel engine checked against a scoreboard of golden writes
module tb_sobel_stream_engine;
    localparam int DW = 8;
    localparam int AW = 4;
    localparam int W  = 4;
    localparam int H  = 4;
    localparam int N  = W * H;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int            t;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [DW-1:0] src_mem [N];
    logic [DW-1:0] dst_mem [N];
    exp_t sb[$];
    exp_t e;
    int total = 0, pass = 0, ecnt = 0, done_cnt = 0, wr_cnt = 0, wr_snap;
    bit running = 1'b0;

    always #5 clk = ~clk;

    sobel_stream_engine_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    sobel_stream_engine #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .IMG_W(W), .IMG_H(H)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // source and destination DPBRAM models
    always @(posedge clk) begin
        if (bus.src_ce) bus.src_q <= src_mem[bus.src_addr];
        if (bus.dst_we) dst_mem[bus.dst_addr] <= bus.dst_d;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass++;
        else $error("FAIL %s got %0d want %0d", tag, obs, exp);
    endtask

    // write monitor: pops the scoreboard and tracks enabled-cycle index since the run began
    always @(negedge clk) begin
        if (rst) begin
            running = 1'b0;
            ecnt    = 0;
        end else begin
            if (bus.o_read && !running) begin
                running = 1'b1;
                ecnt    = 0;
            end
            if (bus.o_done) done_cnt++;
            if (bus.dst_we) begin
                wr_cnt++;
                chk("we_implies_ce", bus.dst_ce, 1);
                chk("o_write_eq_we", bus.o_write, 1);
                total++;
                assert (sb.size() > 0) pass++;
                else $error("FAIL unexpected_write got addr %0d want no write", bus.dst_addr);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("wr_addr", bus.dst_addr, e.a);
                    chk("wr_data", bus.dst_d, e.d);
                    chk("wr_cycle", ecnt, e.t);
                end
            end
            if (bus.i_en && running) ecnt++;
            if (bus.o_done) running = 1'b0;
        end
    end

    function automatic int px(input int r, input int c);
        return int'(src_mem[r * W + c]);
    endfunction

    task automatic build(input bit mode, input logic [DW-1:0] th);
        int gx, gy, m;
        sb.delete();
        for (int r = 1; r < H - 1; r++)
            for (int c = 1; c < W - 1; c++) begin
                gx = px(r - 1, c + 1) + 2 * px(r, c + 1) + px(r + 1, c + 1)
                   - px(r - 1, c - 1) - 2 * px(r, c - 1) - px(r + 1, c - 1);
                gy = px(r + 1, c - 1) + 2 * px(r + 1, c) + px(r + 1, c + 1)
                   - px(r - 1, c - 1) - 2 * px(r - 1, c) - px(r - 1, c + 1);
                m = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
                if (m > 255) m = 255;
                if (mode) m = (m >= int'(th)) ? 255 : 0;
                sb.push_back('{a: AW'(r * W + c), d: DW'(m), t: (r + 1) * W + c + 1 + 3});
            end
    endtask

    // kind 0 = flat, 1 = step (cols 0-1 zero, cols 2-3 = hi), 2 = random
    task automatic load(input int kind, input int hi);
        for (int i = 0; i < N; i++) begin
            src_mem[i] = kind == 0 ? 8'(hi) : kind == 1 ? ((i % W) >= 2 ? 8'(hi) : 8'd0) : 8'($urandom_range(0, 255));
            dst_mem[i] = 8'h5A;
        end
    endtask

    task automatic run(input bit mode, input logic [DW-1:0] th, input bit rnd_en, input bit spam, input string tag);
        build(mode, th);
        done_cnt     = 0;
        bus.i_en     = 1'b1;
        bus.i_run    = 1'b1;
        bus.i_mode   = mode;
        bus.i_thresh = th;
        @(posedge clk); #1;
        bus.i_run = 1'b0;
        if (rnd_en) begin
            bus.i_mode   = ~mode;
            bus.i_thresh = ~th;
        end
        for (int k = 0; k < 400 && !bus.o_idle; k++) begin
            bus.i_en  = rnd_en ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.i_run = spam;
            @(posedge clk); #1;
        end
        bus.i_run = 1'b0;
        bus.i_en  = 1'b1;
        chk({tag, "_finished"}, bus.o_idle, 1);
        chk({tag, "_done_cnt"}, done_cnt, 1);
        chk({tag, "_sb_empty"}, sb.size(), 0);
        for (int i = 0; i < N; i++)
            if (i / W == 0 || i / W == H - 1 || i % W == 0 || i % W == W - 1)
                chk({tag, "_border"}, dst_mem[i], 8'h5A);
    endtask

    initial begin
        bus.i_en     = 1'b1;
        bus.i_run    = 1'b0;
        bus.i_mode   = 1'b0;
        bus.i_thresh = '0;
        rst          = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_idle", bus.o_idle, 1);
        chk("rst_read", bus.o_read, 0);
        chk("rst_write", bus.o_write, 0);
        chk("rst_done", bus.o_done, 0);
        chk("rst_src_ce", bus.src_ce, 0);
        chk("rst_dst_ce", bus.dst_ce, 0);
        chk("rst_dst_we", bus.dst_we, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        load(0, 10);
        run(0, 8'd0, 0, 0, "flat");
        load(1, 10);
        run(0, 8'd0, 0, 0, "step");
        run(1, 8'd50, 0, 0, "th50");
        run(1, 8'd40, 0, 0, "th40");
        load(1, 100);
        run(0, 8'd0, 0, 0, "sat");
        load(2, 0);
        run(0, 8'd0, 0, 0, "rnd");
        run(0, 8'd0, 1, 0, "rnd_en");
        run(1, 8'd128, 1, 0, "rnd_en_th");
        run(0, 8'd0, 0, 1, "run_spam");

        load(2, 0);
        build(0, 8'd0);
        bus.i_run = 1'b1;
        @(posedge clk); #1;
        bus.i_run = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_idle", bus.o_idle, 1);
        chk("midrst_read", bus.o_read, 0);
        chk("midrst_src_ce", bus.src_ce, 0);
        chk("midrst_dst_we", bus.dst_we, 0);
        rst = 1'b0;
        sb.delete();
        wr_snap = wr_cnt;
        repeat (25) @(posedge clk);
        #1;
        chk("midrst_no_writes", wr_cnt, wr_snap);
        chk("midrst_still_idle", bus.o_idle, 1);
        run(0, 8'd0, 0, 0, "restart");

        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule

// File: doc/sobel_stream_engine.md
SOBEL_STREAM_ENGINE -- requirements
Module: sobel_stream_engine

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, pixel width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 12, memory address width.
REQ-003 SHALL have parameter IMG_W, default 64, image width in pixels (>=3).
REQ-004 SHALL have parameter IMG_H, default 64, image height in pixels (>=3); IMG_W*IMG_H <= 2^ADDR_WIDTH.
REQ-005 SHALL have one clock and a synchronous, active-high reset, with ports as listed below.
REQ-006 clk  input  1  sole clock, rising edge.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 i_en  input  1  clock enable; 0 freezes all state, counters and strobes.
REQ-009 i_run  input  1  start pulse; sampled only in IDLE.
REQ-010 i_mode  input  1  0 = magnitude output, 1 = binary threshold output; latched at start.
REQ-011 i_thresh  input  DATA_WIDTH  threshold for mode 1; latched at start.
REQ-012 o_idle / o_read / o_write / o_done  output  1 each  state flags (IDLE / RUN / any dst write this cycle / DONE).
REQ-013 src_ce, src_addr[ADDR_WIDTH], src_q[DATA_WIDTH]: read port to the source DPBRAM; q valid 1 cycle after ce.
REQ-014 dst_ce, dst_we, dst_addr[ADDR_WIDTH], dst_d[DATA_WIDTH]: write port to the destination DPBRAM.

Function
REQ-015 FSM SHALL have states IDLE, RUN, DRAIN, DONE; IDLE->RUN on i_run; RUN->DRAIN after last read issued; DRAIN->DONE when the last write is issued; DONE->IDLE after exactly one enabled cycle.
REQ-016 In RUN, one read per enabled cycle SHALL be issued, addresses 0..IMG_W*IMG_H-1 in raster order, src_ce=1.
REQ-017 Two line buffers of IMG_W entries plus a 3x3 window register SHALL hold the neighbourhood; no pixel is read twice.
REQ-018 When the pixel at (r,c) arrives with r>=2 and c>=2, the result for centre (r-1,c-1) SHALL be written at address (r-1)*IMG_W+(c-1), exactly 2 enabled cycles after its src_q is valid.
REQ-019 Border pixels (row 0, row IMG_H-1, col 0, col IMG_W-1) SHALL NOT be written; destination contents there are unchanged.
REQ-020 Gx=(p02+2p12+p22)-(p00+2p10+p20), Gy=(p20+2p21+p22)-(p00+2p01+p02), signed, DATA_WIDTH+3 bits, no overflow.
REQ-021 Magnitude SHALL be |Gx|+|Gy|, saturated to 2^DATA_WIDTH-1.
REQ-022 Mode 0 writes the saturated magnitude; mode 1 writes 2^DATA_WIDTH-1 if magnitude >= latched threshold, else 0.
REQ-023 i_run while not IDLE SHALL be ignored; i_mode/i_thresh changes after start SHALL have no effect.
REQ-024 i_en=0 SHALL suppress src_ce, dst_ce, dst_we and hold all state; resumption SHALL produce identical results.
REQ-025 dst_we implies dst_ce; o_write equals dst_we; o_done is a one-cycle pulse in DONE.

Reset
REQ-026 rst SHALL force IDLE, o_idle=1, o_read=o_write=o_done=0, src_ce=dst_ce=dst_we=0, counters and window zero, at any time including mid-run.
REQ-027 After reset mid-run, no further dst write SHALL occur until a new i_run.

Verification
REQ-028 4x4 image all 10, mode 0 -> 4 writes (addr 5,6,9,10) all 0, o_done pulses once.
REQ-029 4x4, cols 0-1 = 0, cols 2-3 = 10, mode 0 -> addr 5,6,9,10 = 40; mode 1 thresh 50 -> 0; thresh 40 -> 255.
REQ-030 Same step image with cols 2-3 = 100, mode 0 -> interior writes saturate to 255.
REQ-031 i_en toggled pseudo-randomly during run -> dst writes identical in value and order to the i_en=1 run.
REQ-032 rst asserted in RUN, then i_run -> o_idle=1 next cycle, no writes before restart, restarted run matches golden.
REQ-033 i_run pulsed in RUN/DRAIN -> ignored; exactly one o_done per accepted start.
